// File: rtl/sockit_spi_slv.sv
// sockit_spi_slv: single-clock SPI slave. The SPI pins are oversampled in
// the clk domain. MOSI is deserialized into words that are pushed to the
// input queue (qui_*). Words taken from the output queue (quo_*) are
// serialized onto MISO. All four CPOL/CPHA modes are supported. SCLK must
// be no faster than clk/6.
//
// Parameters:
//   SDW  serial word width
//   SDL  log2(SDW), width of the bit counter
//   SYN  synchronizer depth for the SPI inputs (>= 2)
//
// Ports:
//   clk, rst            system clock; asynchronous active-low reset
//   spi_cfg             [0] pha, [1] pol, [6] dir (1 = MSB first)
//   quo_req/dat/grt     output queue; a word is taken when req & grt
//   qui_req/ctl/dat/grt input queue; ctl = {first word since SS, underrun}
//   spi_sclk_i, spi_ss_i, spi_sdi_i   SCLK, active-high SS, MOSI
//   spi_sdo_o, spi_sdo_e              MISO and its output enable
//   sts_ovr, sts_udr    sticky overrun/underrun, cleared when SS asserts
//
// Build option: define SOCKIT_SPI_SLV_LSB_EN so that spi_cfg[6] selects the
// shift direction. When it is undefined, words are always sent and received
// MSB first and spi_cfg[6] is ignored.
module sockit_spi_slv #(
  parameter int SDW = 8,
  parameter int SDL = 3,
  parameter int SYN = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [31:0]    spi_cfg,
  input  logic           quo_req,
  input  logic [SDW-1:0] quo_dat,
  output logic           quo_grt,
  output logic           qui_req,
  output logic [1:0]     qui_ctl,
  output logic [SDW-1:0] qui_dat,
  input  logic           qui_grt,
  input  logic           spi_sclk_i,
  input  logic           spi_ss_i,
  input  logic           spi_sdi_i,
  output logic           spi_sdo_o,
  output logic           spi_sdo_e,
  output logic           sts_ovr,
  output logic           sts_udr
);

  typedef enum logic [1:0] {IDLE, START, ACTIVE} state_t;

  logic [SYN-1:0] sclk_sync, ss_sync, sdi_sync;
  logic           sclk_d;
  logic           sclk_s, ss_s, sdi_s;
  logic           cfg_pha, cfg_pol;
  logic           k_now, k_old, sample_e, shift_e;
  state_t         state;
  logic [SDL-1:0] bit_cnt;
  logic [SDW-1:0] rx_sr, rx_nxt;
  logic [SDW-1:0] tx_sr, tx_shf, tx_buf;
  logic           tx_vld, rx_vld, first_flg, udr_tag;
  logic           quo_xfer, load;
  logic           cfg_unused;

  assign cfg_pha = spi_cfg[0];
  assign cfg_pol = spi_cfg[1];

  // Input synchronizers plus one edge-detect register on SCLK
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync <= '0;
      ss_sync   <= '0;
      sdi_sync  <= '0;
      sclk_d    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYN-2:0], spi_sclk_i};
      ss_sync   <= {ss_sync[SYN-2:0], spi_ss_i};
      sdi_sync  <= {sdi_sync[SYN-2:0], spi_sdi_i};
      sclk_d    <= sclk_s;
    end
  end

  assign sclk_s = sclk_sync[SYN-1];
  assign ss_s   = ss_sync[SYN-1];
  assign sdi_s  = sdi_sync[SYN-1];

  // Folding pol and pha into k makes a rising k the sample edge and a
  // falling k the shift edge in every mode.
  assign k_now    = sclk_s ^ cfg_pol ^ cfg_pha;
  assign k_old    = sclk_d ^ cfg_pol ^ cfg_pha;
  assign sample_e = k_now & ~k_old;
  assign shift_e  = ~k_now & k_old;

`ifdef SOCKIT_SPI_SLV_LSB_EN
  logic cfg_dir;
  assign cfg_dir    = spi_cfg[6];
  assign cfg_unused = &{1'b0, spi_cfg[31:7], spi_cfg[5:2]};
  assign rx_nxt     = cfg_dir ? {rx_sr[SDW-2:0], sdi_s} : {sdi_s, rx_sr[SDW-1:1]};
  assign tx_shf     = cfg_dir ? {tx_sr[SDW-2:0], 1'b1} : {1'b1, tx_sr[SDW-1:1]};
  assign spi_sdo_o  = cfg_dir ? tx_sr[SDW-1] : tx_sr[0];
`else
  assign cfg_unused = &{1'b0, spi_cfg[31:2]};
  assign rx_nxt     = {rx_sr[SDW-2:0], sdi_s};
  assign tx_shf     = {tx_sr[SDW-2:0], 1'b1};
  assign spi_sdo_o  = tx_sr[SDW-1];
`endif

  assign quo_grt  = ~tx_vld;
  assign qui_req  = rx_vld;
  assign quo_xfer = quo_req & ~tx_vld;

  // pha=0 preloads in START; afterwards both phases load on the shift edge
  // that starts a word (bit_cnt back at 0), which replaces the shift.
  assign load = ((state == START) & ~cfg_pha) |
                ((state == ACTIVE) & ss_s & shift_e & (bit_cnt == '0));

  // Control FSM and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      rx_sr     <= '0;
      tx_sr     <= '1;
      tx_buf    <= '0;
      tx_vld    <= 1'b0;
      rx_vld    <= 1'b0;
      first_flg <= 1'b0;
      udr_tag   <= 1'b0;
      qui_ctl   <= 2'b00;
      qui_dat   <= '0;
      spi_sdo_e <= 1'b0;
      sts_ovr   <= 1'b0;
      sts_udr   <= 1'b0;
    end else begin
      if (qui_req & qui_grt) rx_vld <= 1'b0;

      case (state)
        IDLE: begin
          if (ss_s) state <= START;
        end
        START: begin
          sts_ovr   <= 1'b0;
          sts_udr   <= 1'b0;
          first_flg <= 1'b1;
          udr_tag   <= 1'b0;
          spi_sdo_e <= 1'b1;
          state     <= ACTIVE;
        end
        ACTIVE: begin
          if (!ss_s) begin
            // Partial words are dropped; queued data on both sides survives.
            state     <= IDLE;
            spi_sdo_e <= 1'b0;
            bit_cnt   <= '0;
            rx_sr     <= '0;
            tx_sr     <= '1;
          end else begin
            if (sample_e) begin
              rx_sr <= rx_nxt;
              if (bit_cnt == SDL'(SDW-1)) begin
                bit_cnt   <= '0;
                first_flg <= 1'b0;
                // A grant in this same cycle frees the slot for the new word.
                if (!rx_vld || qui_grt) begin
                  qui_dat <= rx_nxt;
                  qui_ctl <= {first_flg, udr_tag};
                  rx_vld  <= 1'b1;
                end else begin
                  sts_ovr <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
            if (shift_e && !load) tx_sr <= tx_shf;
          end
        end
        default: state <= IDLE;
      endcase

      if (load) begin
        tx_sr   <= tx_vld ? tx_buf : '1;
        udr_tag <= ~tx_vld;
        if (!tx_vld) sts_udr <= 1'b1;
      end

      if (quo_xfer) begin
        tx_buf <= quo_dat;
        tx_vld <= 1'b1;
      end else if (load) begin
        tx_vld <= 1'b0;
      end
    end
  end

endmodule

// File: doc/sockit_spi_slv.md
Name: sockit_spi_slv

Overview:
- Single-clock SPI slave: oversamples SCLK, SS and MOSI in the `clk` domain.
- Deserializes MOSI into words pushed to an input queue; serializes words from an output queue onto MISO.
- Standard 4-wire, single-bit, all four CPOL/CPHA modes.
- Counterpart of the sockit SPI master serializer; used when the device sits on a foreign SPI bus.

Parameters:
SDW  8  serial data word width (bits per transfer word)
SDL  3  log2(SDW), bit counter width
SYN  2  synchronizer depth for spi_sclk_i, spi_ss_i, spi_sdi_i (min 2)

Ports:
clk        input   1    system clock, all logic on posedge
rst        input   1    asynchronous reset, active-low
spi_cfg    input   32   config: [0] pha, [1] pol, [6] dir (1=MSB first); others ignored
quo_req    input   1    output queue request (word to send on MISO)
quo_dat    input   SDW  output queue data
quo_grt    output  1    output queue grant
qui_req    output  1    input queue request (received word valid)
qui_ctl    output  2    {first word since SS assert, underrun occurred during this word}
qui_dat    output  SDW  received word
qui_grt    input   1    input queue grant
spi_sclk_i input   1    SCLK from bus
spi_ss_i   input   1    slave select, active-high (inverter at pad)
spi_sdi_i  input   1    MOSI
spi_sdo_o  output  1    MISO
spi_sdo_e  output  1    MISO output enable
sts_ovr    output  1    sticky overrun flag, cleared on SS assertion
sts_udr    output  1    sticky underrun flag, cleared on SS assertion

Behaviour:
- Reset (rst=0): all sync stages 0; state IDLE; holding registers empty; quo_grt=1, qui_req=0, qui_ctl=0, qui_dat=0, spi_sdo_o=1, spi_sdo_e=0, sts_ovr=0, sts_udr=0.
- Sync and edge detect:
  - SYN-stage synchronizers, then one edge-detect register.
  - Bus event to internal action latency = SYN+1 clk.
  - SCLK frequency must be <= clk/6.
  - k = sclk_s ^ pol ^ pha. Rising k = sample edge; falling k = shift edge.
- Transmit:
  - 1-entry holding register tx_buf with valid tx_vld.
  - quo_grt = ~tx_vld. A quo transfer (quo_req & quo_grt) sets tx_vld.
  - Load: shift register tx_sr <= tx_buf, tx_vld cleared. Same-cycle load and quo transfer is legal: the new word enters tx_buf.
  - Load with tx_vld=0: tx_sr <= all ones, sts_udr set, udr tag carried into qui_ctl[0] of this word.
  - spi_sdo_o = tx_sr[SDW-1] (dir=1) or tx_sr[0] (dir=0).
- Load points:
  - pha=0: on SS assert detect, and on the shift edge following the SDW-th sample edge.
  - pha=1: on the shift edge with bit_cnt==0. This edge loads instead of shifting.
  - Other shift edges: tx_sr shifts by one toward the output bit.
- Receive:
  - Sample edge shifts spi_sdi_i into rx_sr; bit_cnt increments, wrapping SDW-1 -> 0.
  - At wrap:
    - If rx_vld=0: qui_dat <= completed word, rx_vld=1, qui_ctl updated.
    - If rx_vld=1: word discarded, sts_ovr set, existing qui_dat unchanged.
  - qui_req = rx_vld; qui_req & qui_grt clears rx_vld.
  - Wrap coinciding with qui transfer: the new word is accepted, no overrun.
- States:
  - IDLE (ss_s=0): spi_sdo_e=0, bit_cnt=0.
  - START (1 clk on SS assert detect): clear sts_ovr/sts_udr, set first flag, pha=0 load.
  - ACTIVE: shift/sample per edges; spi_sdo_e=1.
  - ACTIVE -> IDLE on SS deassert detect. A mid-word deassert discards the partial rx_sr and tx_sr (the consumed tx word is lost), resets bit_cnt, and keeps rx_vld/qui_dat and tx_buf.
- qui_ctl[1] (first) is set only on the first word completed after START.
- SCLK edges while IDLE are ignored.
- rst asserted mid-transfer returns everything to reset values immediately.

Optional Feature:
- SOCKIT_SPI_SLV_LSB_EN defined: spi_cfg[6] selects shift direction for both rx and tx (0 = LSB first).
- Undefined: spi_cfg[6] ignored, MSB first always, direction mux removed.

Test Plan:
- Mode 0, tx_buf preloaded 0xA5, master sends 0x3C -> MISO bits 1,0,1,0,0,1,0,1; qui_dat=0x3C, qui_ctl=2'b10, sts_*=0.
- Mode 3, two back-to-back words 0x81 then 0x7E queued, master sends 0x12, 0x34 -> MISO 0x81 then 0x7E; qui receives 0x12 (first=1) then 0x34 (first=0).
- No quo word queued, master clocks one word -> MISO 0xFF, sts_udr=1, qui_ctl[0]=1; next SS assert clears sts_udr.
- qui_grt held 0, master sends 0x11, 0x22, 0x33 -> qui_dat stays 0x11, sts_ovr=1; after grant the second qui_req never appears.
- SS deasserted after 5 bits of 0xF0, then full word 0x55 -> no qui_req for the partial word; next qui_dat=0x55 with first=1, bit alignment correct.
- With SOCKIT_SPI_SLV_LSB_EN, cfg[6]=0, tx 0x01, rx 0x80 sent LSB first -> first MISO bit 1; qui_dat=0x80.
